// File: rtl/motion_pkg.sv
// motion_pkg: shared types and helpers for the motion scheduler.
//   dir_t       - movement direction held in cur_dir and the turn queue
//   state_t     - scheduler state encoding (matches the 2-bit state output)
//   KEY_*       - USB keycodes recognised by the scheduler
//   reverse_dir - opposite direction (NONE maps to NONE)
//   key_to_dir  - direction for a keycode, NONE for anything else
package motion_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_HIT   = 2'b11
  } state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  function automatic dir_t reverse_dir(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_NONE;
    endcase
  endfunction

  function automatic dir_t key_to_dir(input logic [7:0] k);
    case (k)
      KEY_W:   return DIR_UP;
      KEY_S:   return DIR_DOWN;
      KEY_A:   return DIR_LEFT;
      KEY_D:   return DIR_RIGHT;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// dir_fifo: two-entry FIFO of pending turns.
//   clk, rst       - clock, synchronous active-high reset
//   flush          - empty the queue (wins over push/pop)
//   push, push_dir - enqueue push_dir
//   pop            - dequeue head
//   head, tail     - oldest and newest entries (tail = head when one entry)
//   full, empty    - occupancy flags
//   count          - number of entries (0..2)
// Push and pop in the same cycle is accepted even when full: the pop frees
// the slot the push lands in.
module dir_fifo
  import motion_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  dir_t       push_dir,
  input  logic       pop,
  output dir_t       head,
  output dir_t       tail,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  dir_t       slot0_q, slot0_d;
  dir_t       slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic [1:0] post_pop;
  logic       do_pop;
  logic       do_push;

  always_comb begin
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'(DEPTH)) || do_pop);
    post_pop = do_pop ? (count_q - 2'd1) : count_q;

    if (flush) begin
      slot0_d = DIR_NONE;
      slot1_d = DIR_NONE;
      count_d = 2'd0;
    end else begin
      if (do_pop) begin
        slot0_d = slot1_q;
        slot1_d = DIR_NONE;
      end
      if (do_push) begin
        if (post_pop == 2'd0) slot0_d = push_dir;
        else                  slot1_d = push_dir;
      end
      count_d = do_push ? (post_pop + 2'd1) : post_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= DIR_NONE;
      slot1_q <= DIR_NONE;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head  = slot0_q;
  assign tail  = (count_q == 2'd2) ? slot1_q : slot0_q;
  assign full  = (count_q == 2'(DEPTH));
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/motion_scheduler.sv
// motion_scheduler: paces ball moves from keyboard direction presses.
//   frame_clk          - one edge per video frame
//   Reset              - synchronous, active-high
//   keycode            - current USB keycode (0 = none)
//   PosX, PosY, Size   - current ball centre and half-size
//   Motion_X, Motion_Y - two's-complement delta for this step (registered)
//   move_en            - one-cycle strobe: apply Motion to position
//   state              - 00 IDLE, 01 RUN, 10 PAUSE, 11 HIT
//   q_count            - pending turns (0..2)
// Build option MOTION_SPEEDUP_EN: every 8 moves the step period shrinks by
// one frame (floor 1); restored on Reset or on returning to IDLE.
//
// state | meaning
// IDLE  | waiting for the first direction key, counter held at 0
// RUN   | counting frames, moves on terminal count
// PAUSE | counter frozen, queue kept, direction keys ignored
// HIT   | a move would leave the playfield; waits for SPACE
module motion_scheduler
  import motion_pkg::*;
#(
  parameter int STEP_PERIOD = 4,
  parameter int STEP_SIZE   = 1,
  parameter int QUEUE_DEPTH = 2,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] PosX,
  input  logic [9:0] PosY,
  input  logic [9:0] Size,
  output logic [9:0] Motion_X,
  output logic [9:0] Motion_Y,
  output logic       move_en,
  output logic [1:0] state,
  output logic [1:0] q_count
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_PAUSE = ST_PAUSE;
  localparam logic [1:0] S_HIT   = ST_HIT;

  localparam int          CW     = $clog2(STEP_PERIOD + 1);
  localparam logic [9:0]  STEP10 = 10'(STEP_SIZE);
  localparam logic [10:0] SS11   = 11'(STEP_SIZE);
  localparam logic [10:0] XMIN11 = 11'(X_MIN);
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] YMIN11 = 11'(Y_MIN);
  localparam logic [10:0] YMAX11 = 11'(Y_MAX);

  logic [1:0]    state_q, state_d;
  dir_t          cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    prev_q;
  logic [9:0]    mx_q, mx_d;
  logic [9:0]    my_q, my_d;
  logic          move_q, move_d;
  logic [CW-1:0] period_w;

  logic       key_evt, space_evt, dir_evt;
  dir_t       key_dir, step_dir, ref_dir;
  logic       tc, blocked;
  logic       push_req, pop_req, flush_req;
  dir_t       fifo_head, fifo_tail;
  logic       fifo_full, fifo_empty;
  logic [1:0] fifo_count;
  logic [10:0] px, py, sz;

  dir_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk      (frame_clk),
    .rst      (Reset),
    .flush    (flush_req),
    .push     (push_req),
    .push_dir (key_dir),
    .pop      (pop_req),
    .head     (fifo_head),
    .tail     (fifo_tail),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign key_evt   = (keycode != prev_q);
  assign key_dir   = key_to_dir(keycode);
  assign space_evt = key_evt && (keycode == KEY_SPACE);
  assign dir_evt   = key_evt && (key_dir != DIR_NONE);
  assign tc        = (cnt_q == (period_w - CW'(1)));
  assign step_dir  = fifo_empty ? cur_q : fifo_head;
  // With a pop this cycle the post-pop tail is still the current tail, and
  // when a single entry is popped it becomes cur_dir, so one mux covers both.
  assign ref_dir   = fifo_empty ? cur_q : fifo_tail;

  assign px = {1'b0, PosX};
  assign py = {1'b0, PosY};
  assign sz = {1'b0, Size};

  // Low-edge checks are rearranged so a ball already past the edge cannot
  // wrap around and look legal.
  always_comb begin
    blocked = 1'b0;
    case (step_dir)
      DIR_UP:    blocked = (py < (sz + YMIN11 + SS11));
      DIR_DOWN:  blocked = ((py + sz + SS11) > YMAX11);
      DIR_LEFT:  blocked = (px < (sz + XMIN11 + SS11));
      DIR_RIGHT: blocked = ((px + sz + SS11) > XMAX11);
      default:   blocked = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    mx_d      = mx_q;
    my_d      = my_q;
    move_d    = 1'b0;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    flush_req = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        mx_d  = '0;
        my_d  = '0;
        if (dir_evt) begin
          cur_d   = key_dir;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (space_evt) begin
          // pause beats a same-cycle move; the count stays where it is
          state_d = S_PAUSE;
        end else begin
          pop_req = tc && !fifo_empty;
          if (dir_evt && (!fifo_full || pop_req) &&
              (key_dir != ref_dir) && (key_dir != reverse_dir(ref_dir))) begin
            push_req = 1'b1;
          end
          if (tc) begin
            cnt_d = '0;
            cur_d = step_dir;
            if (blocked) begin
              state_d = S_HIT;
              mx_d    = '0;
              my_d    = '0;
            end else begin
              move_d = 1'b1;
              mx_d   = '0;
              my_d   = '0;
              case (step_dir)
                DIR_UP:    my_d = 10'd0 - STEP10;
                DIR_DOWN:  my_d = STEP10;
                DIR_LEFT:  mx_d = 10'd0 - STEP10;
                DIR_RIGHT: mx_d = STEP10;
                default:   ;
              endcase
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_PAUSE: begin
        if (space_evt) state_d = S_RUN;
      end

      default: begin
        mx_d = '0;
        my_d = '0;
        if (space_evt) begin
          state_d   = S_IDLE;
          flush_req = 1'b1;
          cur_d     = DIR_NONE;
          cnt_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cur_q   <= DIR_NONE;
      cnt_q   <= '0;
      prev_q  <= 8'h00;
      mx_q    <= '0;
      my_q    <= '0;
      move_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      prev_q  <= keycode;
      mx_q    <= mx_d;
      my_q    <= my_d;
      move_q  <= move_d;
    end
  end

`ifdef MOTION_SPEEDUP_EN
  logic [CW-1:0] period_q, period_d;
  logic [2:0]    mcnt_q, mcnt_d;

  always_comb begin
    period_d = period_q;
    mcnt_d   = mcnt_q;
    if (state_d == S_IDLE) begin
      period_d = CW'(STEP_PERIOD);
      mcnt_d   = 3'd0;
    end else if (move_d) begin
      mcnt_d = mcnt_q + 3'd1;
      if ((mcnt_q == 3'd7) && (period_q > CW'(1))) period_d = period_q - CW'(1);
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      period_q <= CW'(STEP_PERIOD);
      mcnt_q   <= 3'd0;
    end else begin
      period_q <= period_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign period_w = period_q;
`else
  assign period_w = CW'(STEP_PERIOD);
`endif

  assign Motion_X = mx_q;
  assign Motion_Y = my_q;
  assign move_en  = move_q;
  assign state    = state_q;
  assign q_count  = fifo_count;

endmodule
